// File: rtl/fb_scanout.sv
// rtl/fb_scanout.sv - VGA raster timing generator that scans the framebuffer through the palette
// Counter values reach the pins 3 clocks later: fb read, palette read, then the output register.
module fb_scanout #(
    parameter int RESOLUTION_X   = 400,
    parameter int RESOLUTION_Y   = 300,
    parameter int PALETTE_LENGTH = 256,
    parameter int COLOR_BITS     = 12,
    parameter int SCALE          = 2,
    parameter int H_VISIBLE      = 800,
    parameter int H_FRONT        = 40,
    parameter int H_SYNC         = 128,
    parameter int H_BACK         = 88,
    parameter int V_VISIBLE      = 600,
    parameter int V_FRONT        = 1,
    parameter int V_SYNC         = 4,
    parameter int V_BACK         = 23,
    parameter int SYNC_POL       = 1
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    output logic [$clog2(RESOLUTION_X)-1:0]   o_fb_rd_x,
    output logic [$clog2(RESOLUTION_Y)-1:0]   o_fb_rd_y,
    input  logic [$clog2(PALETTE_LENGTH)-1:0] i_fb_rd_index,
    output logic [$clog2(PALETTE_LENGTH)-1:0] o_palette_rd_index,
    input  logic [COLOR_BITS-1:0]             i_palette_rd_color,
    output logic                              o_vga_hsync,
    output logic                              o_vga_vsync,
    output logic [COLOR_BITS-1:0]             o_vga_rgb,
    output logic                              o_vblank,
    output logic                              o_frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(RESOLUTION_X);
    localparam int YW      = $clog2(RESOLUTION_Y);
    localparam int SHIFT   = $clog2(SCALE);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_VISIBLE);
    localparam logic [VW-1:0] V_VIS      = VW'(V_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic          SP         = 1'(SYNC_POL);

    // Control bits: {frame_start, vblank, vsync, hsync, active}
    localparam logic [4:0] CTL_RST = {1'b0, 1'b0, ~SP, ~SP, 1'b0};

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic [4:0]    r_ctl_d1;
    logic [4:0]    r_ctl_d2;

    logic          w_h_vis;
    logic          w_v_vis;
    logic          w_active;
    logic          w_hsync;
    logic          w_vsync;
    logic [4:0]    w_ctl0;

    assign w_h_vis  = (r_h_cnt < H_VIS);
    assign w_v_vis  = (r_v_cnt < V_VIS);
    assign w_active = w_h_vis && w_v_vis;
    assign w_hsync  = (r_h_cnt >= H_SYNC_BEG && r_h_cnt < H_SYNC_END) ? SP : ~SP;
    assign w_vsync  = (r_v_cnt >= V_SYNC_BEG && r_v_cnt < V_SYNC_END) ? SP : ~SP;
    assign w_ctl0   = {(r_h_cnt == '0) && (r_v_cnt == '0), ~w_v_vis, w_vsync, w_hsync, w_active};

    // Addresses park at 0 during blanking so they never leave the framebuffer.
    assign o_fb_rd_x          = w_active ? r_h_cnt[SHIFT +: XW] : '0;
    assign o_fb_rd_y          = w_active ? r_v_cnt[SHIFT +: YW] : '0;
    assign o_palette_rd_index = i_fb_rd_index;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ctl_d1      <= CTL_RST;
            r_ctl_d2      <= CTL_RST;
            o_vga_rgb     <= '0;
            o_vga_hsync   <= ~SP;
            o_vga_vsync   <= ~SP;
            o_vblank      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            r_ctl_d1      <= w_ctl0;
            r_ctl_d2      <= r_ctl_d1;
            o_vga_rgb     <= r_ctl_d2[0] ? i_palette_rd_color : '0;
            o_vga_hsync   <= r_ctl_d2[1];
            o_vga_vsync   <= r_ctl_d2[2];
            o_vblank      <= r_ctl_d2[3];
            o_frame_start <= r_ctl_d2[4];
        end
    end
endmodule

// File: tb/tb_fb_scanout.sv
// tb/tb_fb_scanout.sv - scoreboard bench for fb_scanout on a reduced raster
module tb_fb_scanout;
    localparam int RX = 8, RY = 4, PL = 256, CB = 12, SC = 2;
    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8, VF = 1, VS = 2, VB = 2;
    localparam int POL = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic [CB-1:0] rgb;
        logic          hs;
        logic          vs;
        logic          vb;
        logic          fs;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    fb_rd_x;
    logic [1:0]    fb_rd_y;
    logic [7:0]    fb_rd_index;
    logic [7:0]    palette_rd_index;
    logic [CB-1:0] palette_rd_color;
    logic [CB-1:0] vga_rgb;
    logic          vga_hsync, vga_vsync, vblank, frame_start;

    logic [7:0]    fb_mem  [RY][RX];
    logic [CB-1:0] pal_mem [PL];

    exp_t q[$];
    int   mh, mv;
    bit   run = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    fb_scanout #(
        .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL), .COLOR_BITS(CB), .SCALE(SC),
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(POL)
    ) dut (
        .i_clk(clk),
        .i_reset(reset),
        .o_fb_rd_x(fb_rd_x),
        .o_fb_rd_y(fb_rd_y),
        .i_fb_rd_index(fb_rd_index),
        .o_palette_rd_index(palette_rd_index),
        .i_palette_rd_color(palette_rd_color),
        .o_vga_hsync(vga_hsync),
        .o_vga_vsync(vga_vsync),
        .o_vga_rgb(vga_rgb),
        .o_vblank(vblank),
        .o_frame_start(frame_start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        fb_rd_index      <= fb_mem[fb_rd_y][fb_rd_x];
        palette_rd_color <= pal_mem[palette_rd_index];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t reset_exp();
        exp_t e;
        e.rgb = '0;
        e.hs  = !POL[0];
        e.vs  = !POL[0];
        e.vb  = 1'b0;
        e.fs  = 1'b0;
        return e;
    endfunction

    function automatic exp_t model(input int h, input int v);
        exp_t e;
        e.rgb = (h < HV && v < VV) ? pal_mem[fb_mem[v / SC][h / SC]] : '0;
        e.hs  = (h >= HV + HF && h < HV + HF + HS) ? POL[0] : !POL[0];
        e.vs  = (v >= VV + VF && v < VV + VF + VS) ? POL[0] : !POL[0];
        e.vb  = (v >= VV);
        e.fs  = (h == 0 && v == 0);
        return e;
    endfunction

    always @(posedge clk) begin
        if (run) begin
            q.push_back(model(mh, mv));
            if (mh == HT - 1) begin
                mh <= 0;
                mv <= (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh <= mh + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            exp_t e;
            if (q.size() == 0) begin
                check_eq("queue_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                check_eq("rgb", vga_rgb, e.rgb);
                check_eq("hsync", vga_hsync, e.hs);
                check_eq("vsync", vga_vsync, e.vs);
                check_eq("vblank", vblank, e.vb);
                check_eq("frame_start", frame_start, e.fs);
            end
            check_eq("fb_rd_x", fb_rd_x, (mh < HV && mv < VV) ? mh / SC : 0);
            check_eq("fb_rd_y", fb_rd_y, (mh < HV && mv < VV) ? mv / SC : 0);
            check_eq("pal_idx", palette_rd_index, fb_rd_index);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rgb"}, vga_rgb, 0);
        check_eq({tag, "_hsync"}, vga_hsync, !POL[0]);
        check_eq({tag, "_vsync"}, vga_vsync, !POL[0]);
        check_eq({tag, "_vblank"}, vblank, 0);
        check_eq({tag, "_fs"}, frame_start, 0);
        check_eq({tag, "_x"}, fb_rd_x, 0);
        check_eq({tag, "_y"}, fb_rd_y, 0);
    endtask

    task automatic start_run();
        @(negedge clk);
        #2;
        q.delete();
        q.push_back(reset_exp());
        q.push_back(reset_exp());
        mh = 0;
        mv = 0;
        reset = 1'b0;
        run = 1'b1;
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #2;
        run = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        repeat (7) @(posedge clk);
    endtask

    task automatic load_phase(input int phase);
        for (int y = 0; y < RY; y++)
            for (int x = 0; x < RX; x++)
                case (phase)
                    0:       fb_mem[y][x] = 8'(x + RX * y);
                    1:       fb_mem[y][x] = 8'($urandom_range(0, 255));
                    default: fb_mem[y][x] = (x == 0 && y == 0) ? 8'd5 : 8'd0;
                endcase
        for (int i = 0; i < PL; i++)
            case (phase)
                0:       pal_mem[i] = {4'h0, 8'(i)};
                1:       pal_mem[i] = 12'hFFF;
                default: pal_mem[i] = (i == 5) ? 12'hABC : 12'h000;
            endcase
    endtask

    initial begin
        load_phase(0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        start_run();
        repeat (2 * FRAME + 10) @(posedge clk);

        apply_reset("ph1");
        load_phase(1);
        start_run();
        repeat (FRAME + 3 * HT + 8) @(posedge clk);
        apply_reset("mid");
        start_run();
        repeat (2 * FRAME + 10) @(posedge clk);

        apply_reset("ph2");
        load_phase(2);
        start_run();
        repeat (2 * FRAME + 10) @(posedge clk);

        @(posedge clk);
        #2;
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
